reg_file_ctrl: RTL and testbench
================================

# reg_file_ctrl

Byte-stream command controller that sits directly upstream of the 8×16 register file and is the only agent driving its `WrEn`/`RdEn`/`Address`/`WrData` inputs. It accepts command and data bytes over a valid/ready handshake, issues single-cycle write or read strobes to the register file, and returns read data on a 16-bit response channel with its own valid/ready handshake. One command is in flight at a time.

## Interface
Parameters:
- `ADDR_W`, default 3: register file address width, legal range 1–7.
- `DATA_W`, default 16: register file data width, a multiple of 8. `NBYTES = DATA_W/8`.

Ports:
- `CLK` in 1: the only clock; all state updates on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `in_data` in 8: command or data byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: controller accepts a byte this cycle.
- `rsp_data` out DATA_W: read result.
- `rsp_valid` out 1: `rsp_data` is valid.
- `rsp_ready` in 1: consumer accepts the response.
- `WrEn` out 1: write strobe to the register file.
- `RdEn` out 1: read strobe to the register file.
- `Address` out ADDR_W: register file address.
- `WrData` out DATA_W: register file write data.
- `RdData` in DATA_W: register file read data, valid the cycle after `RdEn` is sampled.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `err` out 1: one-cycle pulse on an illegal command (see Configuration).

## Operation
- A byte transfer happens when `in_valid && in_ready` on a rising edge. A response transfer happens when `rsp_valid && rsp_ready`.
- Command byte layout:
  - bit7 = 1 for a write, 0 for a read.
  - bits[ADDR_W-1:0] = address.
  - bits[6:ADDR_W] are reserved.
- FSM states: IDLE, WDATA, WRITE, READ, RWAIT, RESP.
  - IDLE: `in_ready=1`.
    - A write command latches the address, clears the byte counter and goes to WDATA.
    - A read command latches the address and goes to READ.
  - WDATA: `in_ready=1`. Each accepted byte shifts into `WrData`, MSB first. After byte `NBYTES` is accepted, go to WRITE. Cycles with `in_valid=0` are allowed and the FSM waits with no timeout.
  - WRITE: `WrEn=1` for exactly one cycle with `Address`/`WrData` stable, then go to IDLE.
  - READ: `RdEn=1` for exactly one cycle, then go to RWAIT.
  - RWAIT: capture `RdData` into `rsp_data` at the end of the cycle, then go to RESP.
  - RESP: `rsp_valid=1`. Hold `rsp_data` stable until `rsp_ready`, then go to IDLE.
- `in_ready=0` in WRITE, READ, RWAIT and RESP. No byte is dropped or buffered.
- `WrEn` and `RdEn` are registered outputs. They are never high simultaneously and never high outside WRITE and READ respectively.
- `Address` and `WrData` hold their last values in IDLE. `WrData` is all-ones-free: only bytes actually received are shifted in.

## Timing
- Reset values: state=IDLE, `in_ready=1`, `rsp_valid=0`, `rsp_data=0`, `WrEn=0`, `RdEn=0`, `Address=0`, `WrData=0`, `busy=0`, `err=0`.
- Asserting `RST` in any state aborts the command immediately. A partial write is never issued and a pending response is discarded.
- Write, back-to-back bytes with the command accepted at cycle 0: data bytes at cycles 1..NBYTES, `WrEn` high at cycle NBYTES+1, `in_ready` high again at cycle NBYTES+2.
- Read, command accepted at cycle 0:
  - `RdEn` high in cycle 1.
  - `RdData` captured at the end of cycle 2.
  - `rsp_valid` high from cycle 3.
  - With `rsp_ready` held at 1, `in_ready` is high in cycle 4.
- Minimum command throughput: write = NBYTES+2 cycles, read = 4 cycles.
- `rsp_valid` is never deasserted before the response is accepted.

## Configuration
- Macro `REGF_CTRL_ERR_EN`.
- Defined: a command byte with any reserved bit set is consumed and discarded. `err` pulses high for one cycle in the following cycle, no strobe is issued, and the FSM stays in IDLE.
- Undefined: reserved bits are ignored, the command executes normally, and `err` is tied to 0.

## Test plan
- Reset values: assert `RST` for 2 cycles -> every output equals its reset value and `in_ready=1`.
- Write then read back:
  - Send 0x81, 0x00, 0x03 -> `WrEn` pulses once with `Address=1`, `WrData=0x0003`.
  - Then send 0x01 -> `rsp_data=0x0003` with `rsp_valid` in cycle 3.
- Response backpressure:
  - Write 0x0033 to address 6, then read address 6 with `rsp_ready=0` for 5 cycles -> `rsp_valid` and `rsp_data=0x0033` held stable, `in_ready=0` throughout.
  - Raise `rsp_ready` -> `in_ready=1` on the next cycle.
- Gapped write and mid-operation reset:
  - Send 0x82, then 0xAB with 3 idle cycles between the data bytes, then 0xCD -> `WrData=0xABCD` at address 2.
  - Repeat, asserting `RST` after the first data byte -> no `WrEn` pulse and the state returns to IDLE.
- Reserved bits, command 0x48:
  - With `REGF_CTRL_ERR_EN` defined -> `err` pulses once, with no `RdEn`/`WrEn`.
  - With the macro undefined -> read of address 0 is executed and `err` stays 0.

Source files
------------

// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl
//   Byte-stream command controller that drives the write/read side of an
//   8x16 register file. Command and data bytes arrive on a valid/ready
//   byte channel. Writes are issued as a single-cycle WrEn strobe and reads
//   as a single-cycle RdEn strobe. Read results come back on a DATA_W-wide
//   response channel with its own valid/ready handshake. Only one command
//   is in flight at a time.
//
// Optional feature macro: REGF_CTRL_ERR_EN
//   Defined   : a command byte with any reserved bit set (bits 6..ADDR_W) is
//               consumed and dropped, and err pulses for one cycle.
//   Undefined : reserved bits are ignored and err is tied low.
//
// Ports
//   CLK        in   clock, all state changes on the rising edge
//   RST        in   asynchronous active-high reset, aborts any command
//   in_data    in   command or data byte
//   in_valid   in   in_data is valid
//   in_ready   out  controller accepts a byte this cycle (IDLE / WDATA)
//   rsp_data   out  read result, held stable while rsp_valid is high
//   rsp_valid  out  response available (RESP state)
//   rsp_ready  in   consumer accepts the response
//   WrEn       out  registered write strobe to the register file
//   RdEn       out  registered read strobe to the register file
//   Address    out  register file address
//   WrData     out  register file write data
//   RdData     in   register file read data, valid the cycle after RdEn
//   busy       out  FSM is not in IDLE
//   err        out  one-cycle pulse on an illegal command
module reg_file_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              WrEn,
  output logic              RdEn,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WrData,
  input  logic [DATA_W-1:0] RdData,
  output logic              busy,
  output logic              err
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    WRITE,
    READ,
    RWAIT,
    RESP
  } state_t;

  state_t state;
  state_t next_state;

  logic [CNT_W-1:0] byte_cnt;
  logic             in_fire;
  logic             cmd_write;
  logic             cmd_illegal;
  logic             last_byte;

  assign in_fire   = in_valid && in_ready;
  assign cmd_write = in_data[7];
  assign last_byte = (byte_cnt == CNT_W'(NBYTES - 1));

`ifdef REGF_CTRL_ERR_EN
  // Any set bit above the address field marks the command as illegal.
  assign cmd_illegal = ((in_data[6:0] >> ADDR_W) != 7'd0);
`else
  // Reserved bits carry no meaning in this build.
  logic unused_rsvd;
  assign unused_rsvd = ^in_data[6:0];
  assign cmd_illegal = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. WDATA waits indefinitely for data bytes; RESP waits
  // indefinitely for the consumer.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (in_fire && !cmd_illegal) begin
          next_state = cmd_write ? WDATA : READ;
        end
      end
      WDATA: begin
        if (in_fire && last_byte) begin
          next_state = WRITE;
        end
      end
      WRITE:   next_state = IDLE;
      READ:    next_state = RWAIT;
      RWAIT:   next_state = RESP;
      RESP: begin
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    in_ready  = (state == IDLE) || (state == WDATA);
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  // Datapath. The strobes are registered from next_state so that they
  // line up exactly with the WRITE and READ states.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      WrEn     <= 1'b0;
      RdEn     <= 1'b0;
      Address  <= '0;
      WrData   <= '0;
      rsp_data <= '0;
      byte_cnt <= '0;
    end else begin
      WrEn <= (next_state == WRITE);
      RdEn <= (next_state == READ);
      if ((state == IDLE) && in_fire && !cmd_illegal) begin
        Address  <= in_data[ADDR_W-1:0];
        byte_cnt <= '0;
      end
      // Data bytes arrive MSB first, so each new byte enters at the bottom.
      if ((state == WDATA) && in_fire) begin
        WrData   <= (WrData << 8) | DATA_W'(in_data);
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
      if (state == RWAIT) begin
        rsp_data <= RdData;
      end
    end
  end

`ifdef REGF_CTRL_ERR_EN
  // Error pulse appears in the cycle after the illegal command is consumed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err <= 1'b0;
    end else begin
      err <= (state == IDLE) && in_fire && cmd_illegal;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_file_ctrl.sv
// tb_reg_file_ctrl
//   Directed plus randomized bench for reg_file_ctrl. The bench also plays
//   the register file: it stores WrEn writes and returns RdData one cycle
//   after RdEn. A separate reference array holds what every register should
//   contain according to the commands sent, and read responses are checked
//   against that array.
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_reg_file_ctrl;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;
  localparam int NBYTES = DATA_W / 8;

  logic              CLK;
  logic              RST;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              WrEn;
  logic              RdEn;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] WrData;
  logic [DATA_W-1:0] RdData;
  logic              busy;
  logic              err;

  int total;
  int bad;
  int wr_pulses;
  int rd_pulses;

  logic [DATA_W-1:0] rf     [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ref_rf [0:(1<<ADDR_W)-1];

  reg_file_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rsp_data  (rsp_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .WrEn      (WrEn),
    .RdEn      (RdEn),
    .Address   (Address),
    .WrData    (WrData),
    .RdData    (RdData),
    .busy      (busy),
    .err       (err)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Register file stand-in: writes land on the strobe edge, read data is
  // presented in the cycle after RdEn. Strobe counters feed the checks.
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) rf[i] = '0;
    RdData = '0;
  end

  always @(posedge CLK) begin
    if (WrEn) begin
      rf[Address] <= WrData;
      wr_pulses   <= wr_pulses + 1;
    end
    if (RdEn) begin
      RdData    <= rf[Address];
      rd_pulses <= rd_pulses + 1;
    end
  end

  // One comparison: counts it, and reports it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Offers one byte and returns at the falling edge of the cycle after it
  // was accepted. in_ready is state-decoded, so its value at the falling
  // edge decides acceptance at the next rising edge.
  task automatic applyStimulus(input logic [7:0] b);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(negedge CLK);
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  // Full write: command, data bytes MSB first with optional idle gaps, then
  // checks the strobe cycle and the return to IDLE.
  task automatic doWrite(input logic [7:0] cmd, input logic [DATA_W-1:0] data,
                         input int gap);
    int a;
    a = int'(cmd[ADDR_W-1:0]);
    applyStimulus(cmd);
    for (int i = NBYTES - 1; i >= 0; i--) begin
      repeat (gap) @(negedge CLK);
      applyStimulus(data[i*8 +: 8]);
    end
    checkOutput("wr_en", {31'd0, WrEn}, 32'd1);
    checkOutput("wr_addr", 32'(Address), 32'(a));
    checkOutput("wr_data", 32'(WrData), 32'(data));
    checkOutput("wr_no_rd", {31'd0, RdEn}, 32'd0);
    ref_rf[a] = data;
    @(negedge CLK);
    checkOutput("wr_en_low", {31'd0, WrEn}, 32'd0);
    checkOutput("wr_ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  // Full read: checks RdEn in cycle 1, response in cycle 3 held through
  // `stall` cycles of backpressure, and in_ready after acceptance.
  task automatic doRead(input logic [7:0] cmd, input int stall);
    int a;
    a = int'(cmd[ADDR_W-1:0]);
    applyStimulus(cmd);
    checkOutput("rd_en", {31'd0, RdEn}, 32'd1);
    checkOutput("rd_busy", {31'd0, busy}, 32'd1);
    @(negedge CLK);
    checkOutput("rd_en_low", {31'd0, RdEn}, 32'd0);
    checkOutput("rsp_early", {31'd0, rsp_valid}, 32'd0);
    @(negedge CLK);
    for (int s = 0; s < stall; s++) begin
      checkOutput("rsp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("rsp_hold_data", 32'(rsp_data), 32'(ref_rf[a]));
      checkOutput("rsp_hold_ready", {31'd0, in_ready}, 32'd0);
      @(negedge CLK);
    end
    checkOutput("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("rsp_data", 32'(rsp_data), 32'(ref_rf[a]));
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    checkOutput("rsp_done_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rsp_done_valid", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int wr_before;
    int rd_before;
    logic [DATA_W-1:0] rdata;
    logic [7:0]        rcmd;

    total     = 0;
    bad       = 0;
    wr_pulses = 0;
    rd_pulses = 0;
    for (int i = 0; i < (1 << ADDR_W); i++) ref_rf[i] = '0;
    RST       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    rsp_ready = 1'b0;

    // Reset values with reset held for two cycles.
    repeat (2) @(negedge CLK);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("rst_wren", {31'd0, WrEn}, 32'd0);
    checkOutput("rst_rden", {31'd0, RdEn}, 32'd0);
    checkOutput("rst_addr", 32'(Address), 32'd0);
    checkOutput("rst_wrdata", 32'(WrData), 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Write 0x0003 to address 1, then read it back.
    $display("[TB] write/read address 1");
    wr_before = wr_pulses;
    doWrite(8'h81, 16'h0003, 0);
    checkOutput("wr_once", 32'(wr_pulses - wr_before), 32'd1);
    doRead(8'h01, 0);

    // Response backpressure.
    $display("[TB] backpressure on address 6");
    doWrite(8'h86, 16'h0033, 0);
    doRead(8'h06, 5);

    // Gapped write.
    $display("[TB] gapped write to address 2");
    doWrite(8'h82, 16'hABCD, 3);
    doRead(8'h02, 0);

    // Reset after the first data byte must kill the write.
    $display("[TB] reset in the middle of a write");
    wr_before = wr_pulses;
    applyStimulus(8'h82);
    applyStimulus(8'h11);
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_wrdata", 32'(WrData), 32'd0);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    checkOutput("abort_no_wren", 32'(wr_pulses - wr_before), 32'd0);
    checkOutput("abort_ready", {31'd0, in_ready}, 32'd1);
    doRead(8'h02, 0);

    // Reset while a response is pending discards it.
    applyStimulus(8'h06);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checkOutput("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("abort_rsp_data", 32'(rsp_data), 32'd0);

    // Reserved bits in command 0x48.
    $display("[TB] reserved-bit command");
    wr_before = wr_pulses;
    rd_before = rd_pulses;
`ifdef REGF_CTRL_ERR_EN
    applyStimulus(8'h48);
    checkOutput("rsvd_err_pulse", {31'd0, err}, 32'd1);
    checkOutput("rsvd_ready", {31'd0, in_ready}, 32'd1);
    @(negedge CLK);
    checkOutput("rsvd_err_clear", {31'd0, err}, 32'd0);
    checkOutput("rsvd_no_rden", 32'(rd_pulses - rd_before), 32'd0);
    checkOutput("rsvd_no_wren", 32'(wr_pulses - wr_before), 32'd0);
`else
    doRead(8'h48, 0);
    checkOutput("rsvd_err_low", {31'd0, err}, 32'd0);
    checkOutput("rsvd_one_rden", 32'(rd_pulses - rd_before), 32'd1);
    checkOutput("rsvd_no_wren", 32'(wr_pulses - wr_before), 32'd0);
`endif

    // Randomized mix of writes and reads against the reference array.
    $display("[TB] random commands");
    for (int k = 0; k < 24; k++) begin
      rcmd = 8'($urandom_range(0, (1 << ADDR_W) - 1));
      if ($urandom_range(0, 1) == 1) begin
        rdata = DATA_W'($urandom);
        doWrite(8'h80 | rcmd, rdata, int'($urandom_range(0, 2)));
      end else begin
        doRead(rcmd, int'($urandom_range(0, 3)));
      end
    end

    // Final sweep over every register.
    for (int a = 0; a < (1 << ADDR_W); a++) begin
      doRead(8'(a), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
